// File: rtl/serial_tx_engine_if.sv
// FIFO-side handshake of the serial transmit engine:
// show-ahead head word plus a one-cycle pop request.
interface serial_tx_engine_if #(
  parameter int DATA_WIDTH = 9
);
  logic                  empty;
  logic [DATA_WIDTH-1:0] data;
  logic                  data_request;

  modport master (
    output empty,
    output data,
    input  data_request
  );

  modport slave (
    input  empty,
    input  data,
    output data_request
  );
endinterface

// File: rtl/serial_tx_engine.sv
// UART transmit serializer: pops FIFO words and frames them as
// start / 5-8 data bits LSB-first / optional parity / 1-2 stop bits.
module serial_tx_engine #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_WIDTH = 9
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                brgen,
  input  logic                enable,
  input  logic [1:0]          size,
  input  logic [1:0]          parity,
  input  logic                stop2,
  serial_tx_engine_if.slave   fifo,
  output logic                out,
  output logic                busy
);

  localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [TW-1:0] TICK_MAX = TW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [3:0]    bit_q, bit_d;
  logic          stop_q, stop_d;
  logic [7:0]    shift_q, shift_d;
  logic [1:0]    size_q, size_d;
  logic          par_en_q, par_en_d;
  logic          par_bit_q, par_bit_d;
  logic          stop2_q, stop2_d;
  logic          out_q, out_d;
  logic          busy_q, busy_d;
  logic          req_q, req_d;

  logic [7:0] mask;
  logic [7:0] masked;
  logic       pbit;
  logic       bit_end;
  logic       unused_data;

  assign unused_data = ^fifo.data;

  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    bit_d     = bit_q;
    stop_d    = stop_q;
    shift_d   = shift_q;
    size_d    = size_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    stop2_d   = stop2_q;

    mask    = 8'hFF >> (2'd3 - size);
    masked  = fifo.data[7:0] & mask;
    bit_end = (state_q != IDLE) && brgen
              && (tick_q == TICK_MAX);

    // Parity covers only the bits that will actually be sent
    unique case (1'b1)
      parity == 2'b01: pbit = ^masked;
      parity == 2'b10: pbit = ~^masked;
      default:         pbit = 1'b0;
    endcase

    if (state_q != IDLE && brgen) begin
      tick_d = bit_end ? '0 : tick_q + TW'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (req_q) begin
          shift_d   = masked;
          size_d    = size;
          par_en_d  = (parity != 2'b00);
          par_bit_d = pbit;
          stop2_d   = stop2;
          tick_d    = '0;
          bit_d     = '0;
          stop_d    = 1'b0;
          state_d   = START;
        end
      end
      START: begin
        if (bit_end) state_d = DATA;
      end
      DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 4'd1;
          if (bit_d == ({2'b00, size_q} + 4'd5)) begin
            state_d = par_en_q ? PARITY : STOP;
          end
        end
      end
      PARITY: begin
        if (bit_end) state_d = STOP;
      end
      STOP: begin
        if (bit_end) begin
          if (stop2_q && !stop_q) stop_d = 1'b1;
          else                    state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from next-state values, so the pop is
  // requested one cycle ahead and lands exactly on the load cycle.
  always_comb begin
    unique case (state_d)
      START:   out_d = 1'b0;
      DATA:    out_d = shift_d[0];
      PARITY:  out_d = par_bit_q;
      default: out_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
    req_d  = (state_d == IDLE) && enable && !fifo.empty;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      tick_q    <= '0;
      bit_q     <= '0;
      stop_q    <= 1'b0;
      shift_q   <= '0;
      size_q    <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      stop2_q   <= 1'b0;
      out_q     <= 1'b1;
      busy_q    <= 1'b0;
      req_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      stop_q    <= stop_d;
      shift_q   <= shift_d;
      size_q    <= size_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      stop2_q   <= stop2_d;
      out_q     <= out_d;
      busy_q    <= busy_d;
      req_q     <= req_d;
    end
  end

  assign out               = out_q;
  assign busy              = busy_q;
  assign fifo.data_request = req_q;

endmodule

// File: tb/tb_serial_tx_engine.sv
// Bench for serial_tx_engine: FIFO model, frame-level line model
// checked every cycle, plus directed mid-bit samples of the line.
module tb_serial_tx_engine;
  localparam int OS = 16;
  localparam int DW = 9;
  localparam int BRDIV = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       brgen = 1'b0;
  logic       enable = 1'b0;
  logic [1:0] size = 2'd3;
  logic [1:0] parity = 2'd0;
  logic       stop2 = 1'b0;
  logic       out;
  logic       busy;

  serial_tx_engine_if #(.DATA_WIDTH(DW)) fifo_bus ();

  serial_tx_engine #(
    .OVERSAMPLE(OS),
    .DATA_WIDTH(DW)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .brgen  (brgen),
    .enable (enable),
    .size   (size),
    .parity (parity),
    .stop2  (stop2),
    .fifo   (fifo_bus),
    .out    (out),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int req_cnt = 0;
  int req_t[$];
  logic [DW-1:0] fq[$];
  logic req_seen = 1'b0;
  int br_cnt = 0;

  task automatic check(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t",
               nm, got, exp, $time);
    end
  endtask

  // Expected line bits of one frame, index 0 sent first
  function automatic void frame_bits(input logic [7:0] d,
                                     input logic [1:0] sz,
                                     input logic [1:0] par,
                                     input logic st2,
                                     output logic [11:0] b,
                                     output int n);
    int nd;
    logic p;
    nd = int'(sz) + 5;
    p = 1'b0;
    b = '0;
    b[0] = 1'b0;
    n = 1;
    for (int i = 0; i < nd; i++) begin
      b[n] = d[i];
      p = p ^ d[i];
      n++;
    end
    if (par != 2'd0) begin
      b[n] = (par == 2'd1) ? p : (par == 2'd2) ? ~p : 1'b0;
      n++;
    end
    b[n] = 1'b1;
    n++;
    if (st2) begin
      b[n] = 1'b1;
      n++;
    end
  endfunction

  // FIFO and baud pulse driver, updated just after each rising edge
  initial begin
    fifo_bus.empty = 1'b1;
    fifo_bus.data = '0;
    forever begin
      @(posedge clk);
      #1;
      if (req_seen && fq.size() > 0) void'(fq.pop_front());
      req_seen = 1'b0;
      fifo_bus.empty = (fq.size() == 0);
      fifo_bus.data = (fq.size() > 0) ? fq[0] : '0;
      br_cnt = (br_cnt == BRDIV - 1) ? 0 : br_cnt + 1;
      brgen = (br_cnt == BRDIV - 1);
    end
  end

  // Line model: a frame starts on a pop; bit k is on the line while
  // k*OS <= pulses-since-load < (k+1)*OS.
  logic        m_act = 1'b0;
  logic        m_req = 1'b0;
  logic        m_out = 1'b1;
  logic        m_busy = 1'b0;
  logic [11:0] m_bits = '0;
  int          m_n = 0;
  int          m_pulses = 0;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      req_seen = fifo_bus.data_request;
      if (!reset) begin
        m_act = 1'b0;
        m_req = 1'b0;
        m_out = 1'b1;
        m_busy = 1'b0;
      end else begin
        if (fifo_bus.data_request) begin
          req_cnt++;
          req_t.push_back(cyc);
        end
        check("line_out", out, m_out);
        check("line_busy", busy, m_busy);
        check("data_request", fifo_bus.data_request, m_req);
        if (m_req) begin
          frame_bits(fifo_bus.data[7:0], size, parity, stop2,
                     m_bits, m_n);
          m_act = 1'b1;
          m_pulses = 0;
          m_out = m_bits[0];
          m_busy = 1'b1;
          m_req = 1'b0;
        end else if (m_act) begin
          if (brgen) begin
            m_pulses++;
            if (m_pulses / OS == m_n) begin
              m_act = 1'b0;
              m_out = 1'b1;
              m_busy = 1'b0;
              m_req = enable && !fifo_bus.empty;
            end else begin
              m_out = m_bits[m_pulses / OS];
            end
          end
        end else begin
          m_out = 1'b1;
          m_busy = 1'b0;
          m_req = enable && !fifo_bus.empty;
        end
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_req(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (fifo_bus.data_request) begin
        ok = 1'b1;
        break;
      end
    end
    check("wait_req", {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_quiet(input int max);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (!busy && !fifo_bus.data_request && fq.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    check("wait_quiet", {31'd0, ok}, 32'd1);
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_busy_low(input int max);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    check("wait_busy_low", {31'd0, ok}, 32'd1);
  endtask

  // Samples the line in the middle of each bit of the next frame
  task automatic capture_frame(input int nb, input logic [11:0] exp,
                               input string nm, input bit scramble);
    logic [11:0] got;
    bit ok;
    got = '0;
    wait_req(2000, ok);
    if (ok) begin
      repeat (OS * BRDIV / 2) @(negedge clk);
      for (int k = 0; k < nb; k++) begin
        got[k] = out;
        if (scramble && k == 1) begin
          size = 2'd3;
          parity = 2'd1;
          stop2 = 1'b1;
        end
        if (k < nb - 1) repeat (OS * BRDIV) @(negedge clk);
      end
    end
    check(nm, {20'd0, got}, {20'd0, exp});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] fb;
    int fn;
    int g1;
    bit ok;

    repeat (8) @(negedge clk);
    sync();
    reset = 1'b1;
    req_cnt = 0;
    repeat (1000) @(negedge clk);
    check("idle_req_cnt", req_cnt, 0);
    check("idle_out", out, 1);
    check("idle_busy", busy, 0);

    frame_bits(8'hA5, 2'd3, 2'd0, 1'b0, fb, fn);
    check("pin_8n1", fb, 12'h34A);
    check("pin_8n1_len", fn, 10);
    frame_bits(8'h03, 2'd2, 2'd1, 1'b1, fb, fn);
    check("pin_7e2", fb, 12'h606);
    check("pin_7e2_len", fn, 11);
    frame_bits(8'h07, 2'd2, 2'd2, 1'b1, fb, fn);
    check("pin_7o2", fb, 12'h60E);
    frame_bits(8'hFF, 2'd0, 2'd3, 1'b0, fb, fn);
    check("pin_5s1", fb, 12'h0BE);
    check("pin_5s1_len", fn, 8);

    sync();
    size = 2'd3;
    parity = 2'd0;
    stop2 = 1'b0;
    enable = 1'b1;
    req_cnt = 0;
    fq.push_back(9'h0A5);
    capture_frame(10, 12'h34A, "8n1_line", 1'b0);
    wait_quiet(1000);
    check("8n1_pops", req_cnt, 1);

    sync();
    size = 2'd2;
    parity = 2'd1;
    stop2 = 1'b1;
    fq.push_back(9'h003);
    capture_frame(11, 12'h606, "7e2_line", 1'b0);
    wait_quiet(1000);
    sync();
    parity = 2'd2;
    fq.push_back(9'h007);
    capture_frame(11, 12'h60E, "7o2_line", 1'b0);
    wait_quiet(1000);

    sync();
    size = 2'd0;
    parity = 2'd3;
    stop2 = 1'b0;
    fq.push_back(9'h1FF);
    capture_frame(8, 12'h0BE, "5s1_line", 1'b1);
    wait_quiet(1000);

    sync();
    size = 2'd3;
    parity = 2'd0;
    stop2 = 1'b0;
    req_t.delete();
    fq.push_back(9'h055);
    fq.push_back(9'h0AA);
    fq.push_back(9'h0FF);
    capture_frame(10, 12'h2AA, "b2b_line0", 1'b0);
    capture_frame(10, 12'h354, "b2b_line1", 1'b0);
    capture_frame(10, 12'h3FE, "b2b_line2", 1'b0);
    wait_quiet(1000);
    check("b2b_pops", req_t.size(), 3);
    if (req_t.size() == 3) begin
      g1 = req_t[1] - req_t[0];
      check("b2b_gap1_range", {31'd0, (g1 >= 638 && g1 <= 641)}, 1);
      check("b2b_gap2", req_t[2] - req_t[1], 640);
    end

    sync();
    req_cnt = 0;
    fq.push_back(9'h05A);
    fq.push_back(9'h033);
    wait_req(2000, ok);
    repeat (3 * OS * BRDIV + 32) @(negedge clk);
    sync();
    enable = 1'b0;
    wait_busy_low(1000);
    repeat (300) @(negedge clk);
    check("dis_fifo_left", fq.size(), 1);
    check("dis_pops", req_cnt, 1);

    sync();
    enable = 1'b1;
    wait_req(200, ok);
    repeat (3 * OS * BRDIV + 32) @(negedge clk);
    check("pre_rst_out", out, 0);
    sync();
    reset = 1'b0;
    #1;
    check("rst_out", out, 1);
    check("rst_busy", busy, 0);
    check("rst_req", fifo_bus.data_request, 0);
    fq.push_back(9'h00F);
    repeat (5) @(negedge clk);
    sync();
    reset = 1'b1;
    capture_frame(10, 12'h21E, "post_rst_line", 1'b0);
    wait_quiet(1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
